bsg_array_concentrate_sequencer: RTL and testbench

//  Dynamic, sequenced counterpart to the static array concentrator.
//  - Accepts one array of els_p words plus a per-lane valid mask.
//  - Streams only the valid words, lowest lane first, out_els_p words per beat.
//  - Beats are sent over a valid/yumi interface.
//  - Sits between a wide lane-parallel producer and a narrow consumer; sparse arrays drain in fewer beats.

---
 rtl/bsg_array_concentrate_pkg.sv | 15 +
 rtl/bsg_array_concentrate_pick.sv | 42 ++++
 rtl/bsg_array_concentrate_sequencer.sv | 106 ++++++++++
 tb/tb_bsg_array_concentrate_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_array_concentrate_pkg.sv
// Shared types and helpers for the array concentrate sequencer.
package bsg_array_concentrate_pkg;

    // IDLE accepts a new array; SEND streams its valid words out beat by beat.
    typedef enum logic [0:0] {
        eIdle = 1'b0,
        eSend = 1'b1
    } state_e;

    // Width needed to hold a popcount of els lanes (0..els inclusive).
    function automatic int popcount_width(input int els);
        return (els < 1) ? 1 : $clog2(els + 1);
    endfunction

endpackage

// File: rtl/bsg_array_concentrate_pick.sv
// Combinational find-first-N-set: selects the lowest out_els_p set bits of a mask.
// The n-th selected bit is reported as a one-hot select on output lane n, and the
// union of all selected bits is returned so the caller can retire them.
module bsg_array_concentrate_pick
    import bsg_array_concentrate_pkg::*;
#(
    parameter int els_p     = 8,
    parameter int out_els_p = 2
) (
    input  logic [els_p-1:0]                     mask_i,
    output logic [out_els_p-1:0][els_p-1:0]      sel_o,
    output logic [els_p-1:0]                     consumed_o,
    output logic [popcount_width(els_p)-1:0]     count_o
);

    localparam int cnt_w = popcount_width(els_p);

    logic [cnt_w-1:0] run;

    // Walk the mask from lane 0 upward; the running count of set bits below a
    // lane is the output slot that lane lands in, if it lands in one at all.
    always_comb begin
        run        = '0;
        sel_o      = '0;
        consumed_o = '0;
        for (int k = 0; k < els_p; k++) begin
            if (mask_i[k]) begin
                for (int j = 0; j < out_els_p; j++) begin
                    if (run == cnt_w'(j)) begin
                        sel_o[j][k] = 1'b1;
                    end
                end
                if (run < cnt_w'(out_els_p)) begin
                    consumed_o[k] = 1'b1;
                end
            end
            run = run + cnt_w'(mask_i[k]);
        end
        count_o = run;
    end

endmodule

// File: rtl/bsg_array_concentrate_sequencer.sv
// Sequenced array concentrator: captures one lane-parallel array with a valid
// mask, then streams only the valid words (lowest lane first) out_els_p per beat
// over a valid/yumi interface. An empty array still produces one empty last beat
// so that every accepted array is framed on the output side.
module bsg_array_concentrate_sequencer
    import bsg_array_concentrate_pkg::*;
#(
    parameter int width_p   = 8,
    parameter int els_p     = 8,
    parameter int out_els_p = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           v_i,
    input  logic [els_p*width_p-1:0]       data_i,
    input  logic [els_p-1:0]               mask_i,
    output logic                           ready_o,
    output logic                           v_o,
    output logic [out_els_p*width_p-1:0]   data_o,
    output logic [out_els_p-1:0]           lanes_v_o,
    output logic                           last_o,
    input  logic                           yumi_i
);

    localparam int cnt_w = popcount_width(els_p);

    state_e                          state_q;
    logic [els_p*width_p-1:0]        data_q;
    logic [els_p-1:0]                rem_q;
    logic [els_p-1:0]                rem_d;

    logic [out_els_p-1:0][els_p-1:0] sel;
    logic [els_p-1:0]                consumed;
    logic [cnt_w-1:0]                rem_count;
    logic                            sending;
    logic                            last_beat;

    bsg_array_concentrate_pick #(
        .els_p     (els_p),
        .out_els_p (out_els_p)
    ) pick (
        .mask_i     (rem_q),
        .sel_o      (sel),
        .consumed_o (consumed),
        .count_o    (rem_count)
    );

    assign sending   = (state_q == eSend);
    assign last_beat = (rem_count <= cnt_w'(out_els_p));
    assign rem_d     = rem_q & ~consumed;

    assign ready_o   = (state_q == eIdle);
    assign v_o       = sending;
    assign last_o    = sending & last_beat;

    // Route each selected captured word to its output lane; unused lanes read zero.
    always_comb begin
        data_o    = '0;
        lanes_v_o = '0;
        for (int j = 0; j < out_els_p; j++) begin
            lanes_v_o[j] = sending & (|sel[j]);
            for (int k = 0; k < els_p; k++) begin
                if (sending && sel[j][k]) begin
                    data_o[j*width_p +: width_p] = data_q[k*width_p +: width_p];
                end
            end
        end
    end

    // Accept an array in IDLE, retire the sent lanes on each yumi, return to IDLE after the last beat.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= eIdle;
            data_q  <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                eIdle: begin
                    if (v_i) begin
                        data_q  <= data_i;
                        rem_q   <= mask_i;
                        state_q <= eSend;
                    end
                end
                eSend: begin
                    if (yumi_i) begin
                        rem_q <= rem_d;
                        if (last_beat) begin
                            state_q <= eIdle;
                            data_q  <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= eIdle;
                end
            endcase
        end
    end

    // A consumer may only take a beat that is being offered.
    yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o
    );

endmodule

// File: tb/tb_bsg_array_concentrate_sequencer.sv
// Self-checking bench for bsg_array_concentrate_sequencer (width 8, 8 lanes, 2 out lanes).
module tb_bsg_array_concentrate_sequencer;

    localparam int W = 8;
    localparam int E = 8;
    localparam int O = 2;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic             vIn = 1'b0;
    logic [E*W-1:0]   dIn = '0;
    logic [E-1:0]     mIn = '0;
    logic             yumi = 1'b0;
    logic             ready;
    logic             vOut;
    logic [O*W-1:0]   dOut;
    logic [O-1:0]     lanes;
    logic             last;

    bsg_array_concentrate_sequencer #(
        .width_p   (W),
        .els_p     (E),
        .out_els_p (O)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rstN),
        .v_i       (vIn),
        .data_i    (dIn),
        .mask_i    (mIn),
        .ready_o   (ready),
        .v_o       (vOut),
        .data_o    (dOut),
        .lanes_v_o (lanes),
        .last_o    (last),
        .yumi_i    (yumi)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatched = 0;

    typedef struct {
        logic [O*W-1:0] data;
        logic [O-1:0]   lanes;
        logic           last;
    } beat_t;

    beat_t mq[$];
    bit    mIdle = 1'b1;

    logic [O*W-1:0] capData [16];
    logic [O-1:0]   capLanes[16];
    logic           capLast [16];
    int             nCap;

    localparam logic [E*W-1:0] Ramp = 64'h1716151413121110;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL timeout %s: got no event expected event at %0t", name, $time);
    endtask

    // Expected beats of one array: collect the valid words in lane order, then chunk them.
    function automatic void buildBeats(input logic [E*W-1:0] d, input logic [E-1:0] m);
        logic [W-1:0] vals[$];
        beat_t b;
        for (int k = 0; k < E; k++) if (m[k]) vals.push_back(d[k*W +: W]);
        if (vals.size() == 0) begin
            b.data = '0; b.lanes = '0; b.last = 1'b1;
            mq.push_back(b);
        end else begin
            while (vals.size() > 0) begin
                b.data = '0; b.lanes = '0;
                for (int j = 0; j < O && vals.size() > 0; j++) begin
                    b.data[j*W +: W] = vals.pop_front();
                    b.lanes[j] = 1'b1;
                end
                b.last = (vals.size() == 0);
                mq.push_back(b);
            end
        end
    endfunction

    // Reference model: tracks whether an array is in flight and its pending beats.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mq.delete();
            mIdle = 1'b1;
        end else if (mIdle) begin
            if (vIn) begin
                buildBeats(dIn, mIn);
                mIdle = 1'b0;
            end
        end else if (yumi) begin
            beat_t b;
            b = mq.pop_front();
            if (b.last) mIdle = 1'b1;
        end
    end

    // Compare DUT outputs against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        checkOutput("ready_o", 32'(ready), 32'(mIdle));
        checkOutput("v_o", 32'(vOut), 32'(!mIdle));
        if (!rstN) begin
            checkOutput("rst data_o", 32'(dOut), 32'h0);
            checkOutput("rst lanes_v_o", 32'(lanes), 32'h0);
            checkOutput("rst last_o", 32'(last), 32'h0);
        end else if (!mIdle) begin
            if (mq.size() == 0) begin
                timeoutFail("model beat");
            end else begin
                checkOutput("data_o", 32'(dOut), 32'(mq[0].data));
                checkOutput("lanes_v_o", 32'(lanes), 32'(mq[0].lanes));
                checkOutput("last_o", 32'(last), 32'(mq[0].last));
            end
        end
    end

    // Offer one array, then consume all its beats, stalling the first beat for 'stall' cycles.
    task automatic applyStimulus(input logic [E*W-1:0] d, input logic [E-1:0] m, input int stall);
        int guard;
        bit done;
        nCap = 0;
        done = 1'b0;
        vIn = 1'b1; dIn = d; mIn = m;
        guard = 0;
        while (!ready && guard < 50) begin @(posedge clk); #1; guard++; end
        if (!ready) timeoutFail("accept");
        @(posedge clk); #1;
        vIn = 1'b0;
        for (int beat = 0; beat < 16 && !done; beat++) begin
            guard = 0;
            while (!vOut && guard < 50) begin @(posedge clk); #1; guard++; end
            if (!vOut) begin
                timeoutFail("beat");
                done = 1'b1;
            end else begin
                capData[nCap]  = dOut;
                capLanes[nCap] = lanes;
                capLast[nCap]  = last;
                nCap++;
                if (beat == 0) repeat (stall) begin @(posedge clk); #1; end
                yumi = 1'b1;
                @(posedge clk); #1;
                yumi = 1'b0;
                if (capLast[nCap-1]) done = 1'b1;
            end
        end
        if (!done) timeoutFail("last beat");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pop;
        int expBeats;
        logic [E-1:0]   rm;
        logic [E*W-1:0] rd;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset ready_o", 32'(ready), 32'h1);
        checkOutput("reset v_o", 32'(vOut), 32'h0);
        rstN = 1'b1;
        @(posedge clk); #1;

        $display("[TB] test 1: full mask");
        applyStimulus(Ramp, 8'hFF, 0);
        checkOutput("t1 beats", 32'(nCap), 32'd4);
        checkOutput("t1 b0", 32'(capData[0]), 32'h1110);
        checkOutput("t1 b1", 32'(capData[1]), 32'h1312);
        checkOutput("t1 b2", 32'(capData[2]), 32'h1514);
        checkOutput("t1 b3", 32'(capData[3]), 32'h1716);
        checkOutput("t1 lanes", 32'(capLanes[3]), 32'h3);
        checkOutput("t1 last0", 32'(capLast[0]), 32'h0);
        checkOutput("t1 last3", 32'(capLast[3]), 32'h1);
        checkOutput("t1 ready after", 32'(ready), 32'h1);

        $display("[TB] test 2: sparse mask");
        applyStimulus(Ramp, 8'h25, 0);
        checkOutput("t2 beats", 32'(nCap), 32'd2);
        checkOutput("t2 b0", 32'(capData[0]), 32'h1210);
        checkOutput("t2 lanes0", 32'(capLanes[0]), 32'h3);
        checkOutput("t2 last0", 32'(capLast[0]), 32'h0);
        checkOutput("t2 b1", 32'(capData[1]), 32'h0015);
        checkOutput("t2 lanes1", 32'(capLanes[1]), 32'h1);
        checkOutput("t2 last1", 32'(capLast[1]), 32'h1);

        $display("[TB] test 3: empty mask");
        applyStimulus(Ramp, 8'h00, 0);
        checkOutput("t3 beats", 32'(nCap), 32'd1);
        checkOutput("t3 data", 32'(capData[0]), 32'h0);
        checkOutput("t3 lanes", 32'(capLanes[0]), 32'h0);
        checkOutput("t3 last", 32'(capLast[0]), 32'h1);
        checkOutput("t3 ready after", 32'(ready), 32'h1);

        $display("[TB] test 4: backpressure");
        applyStimulus(Ramp, 8'h81, 5);
        checkOutput("t4 beats", 32'(nCap), 32'd1);
        checkOutput("t4 data", 32'(capData[0]), 32'h1710);
        checkOutput("t4 last", 32'(capLast[0]), 32'h1);

        $display("[TB] test 5: reset mid-array");
        vIn = 1'b1; dIn = Ramp; mIn = 8'hFF;
        @(posedge clk); #1;
        vIn = 1'b0;
        yumi = 1'b1;
        @(posedge clk); #1;
        yumi = 1'b0;
        rstN = 1'b0;
        #1;
        checkOutput("t5 v_o in reset", 32'(vOut), 32'h0);
        checkOutput("t5 ready in reset", 32'(ready), 32'h1);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
        checkOutput("t5 ready after", 32'(ready), 32'h1);
        applyStimulus(Ramp, 8'h03, 0);
        checkOutput("t5 beats", 32'(nCap), 32'd1);
        checkOutput("t5 data", 32'(capData[0]), 32'h1110);
        checkOutput("t5 lanes", 32'(capLanes[0]), 32'h3);

        $display("[TB] test 6: v_i during SEND");
        vIn = 1'b1; dIn = Ramp; mIn = 8'h81;
        @(posedge clk); #1;
        dIn = 64'hA7A6A5A4A3A2A1A0; mIn = 8'h0F;
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("t6 data held", 32'(dOut), 32'h1710);
        vIn = 1'b0;
        yumi = 1'b1;
        @(posedge clk); #1;
        yumi = 1'b0;
        checkOutput("t6 ready", 32'(ready), 32'h1);
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("t6 no extra beat", 32'(vOut), 32'h0);

        $display("[TB] random masks");
        for (int i = 0; i < 24; i++) begin
            rm = E'($urandom_range(0, 255));
            rd = {$urandom(), $urandom()};
            applyStimulus(rd, rm, int'($urandom_range(0, 2)));
            pop = $countones(rm);
            expBeats = (pop == 0) ? 1 : (pop + O - 1) / O;
            checkOutput("rand beats", 32'(nCap), 32'(expBeats));
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
